// File: rtl/vram_pkg.sv
// Shared definitions for the 256x256, 3-bit-per-pixel video memory and its draw engine.
// The VGA controller takes its window constants from here as well.
package vram_pkg;

    localparam int unsigned VRAM_COORD_W = 8;
    localparam int unsigned VRAM_ADDR_W  = 16;
    localparam int unsigned COLOR_W      = 3;

    localparam int unsigned VGA_WIN_W    = 256;
    localparam int unsigned VGA_WIN_H    = 256;

    localparam logic OP_PIXEL = 1'b0;
    localparam logic OP_FILL  = 1'b1;

    typedef struct packed {
        logic                    op;
        logic [VRAM_COORD_W-1:0] x;
        logic [VRAM_COORD_W-1:0] y;
        logic [VRAM_COORD_W-1:0] w;
        logic [VRAM_COORD_W-1:0] h;
        logic [COLOR_W-1:0]      color;
    } draw_cmd_t;

    localparam int unsigned CMD_W = $bits(draw_cmd_t);

    // A PIXEL is a FILL of size 1x1, so its width/height fields are forced to zero.
    function automatic logic [VRAM_COORD_W-1:0] cmd_extent(input logic op,
                                                          input logic [VRAM_COORD_W-1:0] size);
        return (op == OP_FILL) ? size : '0;
    endfunction

endpackage

// File: rtl/cmd_fifo.sv
// Synchronous command FIFO with count-based full/empty and asynchronous active-high reset.
module cmd_fifo #(
    parameter int unsigned WIDTH = 36,
    parameter int unsigned DEPTH = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = (r_count == CNT_W'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_data    = r_mem[r_rd_ptr];
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    always_ff @(posedge i_clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_do_push && !w_do_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_do_pop && !w_do_push) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/vram_draw_engine.sv
// Pixel / filled-rectangle draw engine feeding the video memory write port,
// one write per clock, with commands buffered through cmd_fifo.
module vram_draw_engine
    import vram_pkg::*;
#(
    parameter int unsigned CMD_DEPTH = 4
) (
    input  logic                    Clock,
    input  logic                    Reset,
    input  logic                    iCmdValid,
    output logic                    oCmdReady,
    input  logic                    iCmdOp,
    input  logic [VRAM_COORD_W-1:0] iX,
    input  logic [VRAM_COORD_W-1:0] iY,
    input  logic [VRAM_COORD_W-1:0] iW,
    input  logic [VRAM_COORD_W-1:0] iH,
    input  logic [COLOR_W-1:0]      iColor,
    output logic                    oWriteEnable,
    output logic [VRAM_ADDR_W-1:0]  oWriteAddress,
    output logic [COLOR_W-1:0]      oWriteData,
    output logic                    oBusy
);

    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_DRAW = 1'b1;

    logic                    r_state;
    logic [VRAM_COORD_W-1:0] r_cx;
    logic [VRAM_COORD_W-1:0] r_cy;
    logic [VRAM_COORD_W-1:0] r_x;
    logic [VRAM_COORD_W-1:0] r_y;
    logic [VRAM_COORD_W-1:0] r_w;
    logic [VRAM_COORD_W-1:0] r_h;
    logic [COLOR_W-1:0]      r_color;
    logic                    r_we;
    logic [VRAM_ADDR_W-1:0]  r_addr;
    logic [COLOR_W-1:0]      r_data;
    logic                    r_busy;

    draw_cmd_t               w_cmd_in;
    draw_cmd_t               w_head;
    logic                    w_full;
    logic                    w_empty;
    logic                    w_push;
    logic                    w_pop;
    logic                    w_last;
    logic [VRAM_COORD_W-1:0] w_col;
    logic [VRAM_COORD_W-1:0] w_row;

    assign w_cmd_in = '{op: iCmdOp, x: iX, y: iY, w: iW, h: iH, color: iColor};
    assign w_push   = iCmdValid && !w_full;
    assign w_last   = (r_cx == r_w) && (r_cy == r_h);
    // Popping on the last pixel of the current command keeps back-to-back commands gap-free.
    assign w_pop    = !w_empty && ((r_state == ST_IDLE) || w_last);
    assign w_col    = r_x + r_cx;
    assign w_row    = r_y + r_cy;

    cmd_fifo #(
        .WIDTH (CMD_W),
        .DEPTH (CMD_DEPTH)
    ) u_cmd_fifo (
        .i_clk   (Clock),
        .i_rst   (Reset),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_data  (w_cmd_in),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_state <= ST_IDLE;
            r_cx    <= '0;
            r_cy    <= '0;
            r_x     <= '0;
            r_y     <= '0;
            r_w     <= '0;
            r_h     <= '0;
            r_color <= '0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_data  <= '0;
            r_busy  <= 1'b0;
        end else begin
            r_we   <= (r_state == ST_DRAW);
            r_busy <= w_push || !w_empty || (r_state == ST_DRAW);
            if (r_state == ST_DRAW) begin
                r_addr <= {w_row, w_col};
                r_data <= r_color;
            end

            if (w_pop) begin
                r_state <= ST_DRAW;
                r_cx    <= '0;
                r_cy    <= '0;
                r_x     <= w_head.x;
                r_y     <= w_head.y;
                r_w     <= cmd_extent(w_head.op, w_head.w);
                r_h     <= cmd_extent(w_head.op, w_head.h);
                r_color <= w_head.color;
            end else if (r_state == ST_DRAW) begin
                if (w_last) begin
                    r_state <= ST_IDLE;
                end else if (r_cx == r_w) begin
                    r_cx <= '0;
                    r_cy <= r_cy + 1'b1;
                end else begin
                    r_cx <= r_cx + 1'b1;
                end
            end
        end
    end

    assign oCmdReady     = !w_full;
    assign oWriteEnable  = r_we;
    assign oWriteAddress = r_addr;
    assign oWriteData    = r_data;
    assign oBusy         = r_busy;

endmodule

// File: tb/tb_vram_draw_engine.sv
// Scoreboard bench for vram_draw_engine: expected writes are queued at issue time
// and a negedge monitor checks every write the engine presents.
module tb_vram_draw_engine;

    logic        Clock;
    logic        Reset;
    logic        iCmdValid;
    logic        oCmdReady;
    logic        iCmdOp;
    logic [7:0]  iX, iY, iW, iH;
    logic [2:0]  iColor;
    logic        oWriteEnable;
    logic [15:0] oWriteAddress;
    logic [2:0]  oWriteData;
    logic        oBusy;

    typedef struct {
        logic [15:0] addr;
        logic [2:0]  data;
    } exp_wr_t;

    exp_wr_t exp_q[$];
    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int wcount   = 0;
    int first_cyc = 0;
    int last_cyc  = 0;

    vram_draw_engine #(.CMD_DEPTH(4)) dut (
        .Clock         (Clock),
        .Reset         (Reset),
        .iCmdValid     (iCmdValid),
        .oCmdReady     (oCmdReady),
        .iCmdOp        (iCmdOp),
        .iX            (iX),
        .iY            (iY),
        .iW            (iW),
        .iH            (iH),
        .iColor        (iColor),
        .oWriteEnable  (oWriteEnable),
        .oWriteAddress (oWriteAddress),
        .oWriteData    (oWriteData),
        .oBusy         (oBusy)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    always @(posedge Clock) cyc <= cyc + 1;

    // Monitor: every presented write must match the head of the expected queue.
    always @(negedge Clock) begin
        if (oWriteEnable) begin
            if (wcount == 0) first_cyc = cyc;
            last_cyc = cyc;
            wcount = wcount + 1;
            n_checks = n_checks + 1;
            if (exp_q.size() == 0) begin
                n_fail = n_fail + 1;
                $display("FAIL unexpected_write: got addr=%04h data=%03b, required no write", oWriteAddress, oWriteData);
            end else begin
                exp_wr_t e;
                e = exp_q.pop_front();
                if (oWriteAddress !== e.addr || oWriteData !== e.data) begin
                    n_fail = n_fail + 1;
                    $display("FAIL write_data: got addr=%04h data=%03b, required addr=%04h data=%03b",
                             oWriteAddress, oWriteData, e.addr, e.data);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (act !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    task automatic expect_wr(input logic [15:0] a, input logic [2:0] d);
        exp_wr_t e;
        e.addr = a;
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic send(input logic op, input logic [7:0] x, input logic [7:0] y,
                        input logic [7:0] w, input logic [7:0] h, input logic [2:0] c,
                        input int budget, output int acc);
        int waited;
        waited = 0;
        @(negedge Clock);
        iCmdValid = 1'b1;
        iCmdOp = op; iX = x; iY = y; iW = w; iH = h; iColor = c;
        while (!oCmdReady && waited < budget) begin
            @(negedge Clock);
            waited++;
        end
        if (!oCmdReady) begin
            n_checks = n_checks + 1;
            n_fail = n_fail + 1;
            $display("FAIL accept_timeout: got ready=0 after %0d cycles, required ready=1", waited);
            iCmdValid = 1'b0;
            acc = -1;
        end else begin
            @(posedge Clock);
            #1;
            acc = cyc;
            iCmdValid = 1'b0;
        end
    endtask

    task automatic wait_idle(input string name, input int budget);
        int waited;
        waited = 0;
        @(negedge Clock);
        while ((oBusy || exp_q.size() != 0) && waited < budget) begin
            @(negedge Clock);
            waited++;
        end
        chk({name, "_drained"}, (!oBusy && exp_q.size() == 0), 1);
    endtask

    initial begin
        int acc0, acc1, acc5, nb;
        #1500000;
        $display("FAIL watchdog: got simulation time limit, required test completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc0, acc1, acc5, nb, i;
        Reset = 1'b1;
        iCmdValid = 1'b0;
        iCmdOp = 1'b0; iX = '0; iY = '0; iW = '0; iH = '0; iColor = '0;
        repeat (3) @(posedge Clock);
        #1;
        chk("reset_we", oWriteEnable, 0);
        chk("reset_addr", oWriteAddress, 0);
        chk("reset_data", oWriteData, 0);
        chk("reset_busy", oBusy, 0);
        @(negedge Clock);
        Reset = 1'b0;
        @(negedge Clock);
        chk("ready_after_reset", oCmdReady, 1);

        // Single PIXEL; W/H carry junk that must be ignored.
        wcount = 0;
        expect_wr(16'h0205, 3'b101);
        send(1'b0, 8'd5, 8'd2, 8'd7, 8'd3, 3'b101, 10, acc0);
        nb = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge Clock);
            if (oBusy) nb++;
        end
        chk("pixel_write_count", wcount, 1);
        chk("pixel_latency", first_cyc - acc0, 2);
        chk("pixel_busy_1to3", (nb >= 1 && nb <= 3), 1);
        chk("pixel_busy_low", oBusy, 0);
        chk("pixel_queue_empty", exp_q.size(), 0);

        // FILL 3x2 at (10,20)
        wcount = 0;
        expect_wr(16'h140A, 3'b011); expect_wr(16'h140B, 3'b011); expect_wr(16'h140C, 3'b011);
        expect_wr(16'h150A, 3'b011); expect_wr(16'h150B, 3'b011); expect_wr(16'h150C, 3'b011);
        send(1'b1, 8'd10, 8'd20, 8'd2, 8'd1, 3'b011, 10, acc0);
        wait_idle("fill", 100);
        chk("fill_count", wcount, 6);
        chk("fill_contiguous", last_cyc - first_cyc, 5);

        // Wrap in both axes
        wcount = 0;
        expect_wr(16'hFFFE, 3'b110); expect_wr(16'hFFFF, 3'b110); expect_wr(16'hFF00, 3'b110);
        expect_wr(16'h00FE, 3'b110); expect_wr(16'h00FF, 3'b110); expect_wr(16'h0000, 3'b110);
        send(1'b1, 8'd254, 8'd255, 8'd2, 8'd1, 3'b110, 10, acc0);
        wait_idle("wrap", 100);
        chk("wrap_count", wcount, 6);

        // Full clear with five PIXELs queued behind it
        wcount = 0;
        for (i = 0; i < 65536; i++) expect_wr(i[15:0], 3'b000);
        expect_wr(16'h0101, 3'b001);
        expect_wr(16'h0302, 3'b010);
        expect_wr(16'h0504, 3'b011);
        expect_wr(16'h0706, 3'b100);
        expect_wr(16'hFEFF, 3'b111);
        send(1'b1, 8'd0, 8'd0, 8'd255, 8'd255, 3'b000, 10, acc0);
        send(1'b0, 8'd1, 8'd1, 8'd0, 8'd0, 3'b001, 10, acc1);
        send(1'b0, 8'd2, 8'd3, 8'd0, 8'd0, 3'b010, 10, acc1);
        send(1'b0, 8'd4, 8'd5, 8'd0, 8'd0, 3'b011, 10, acc1);
        send(1'b0, 8'd6, 8'd7, 8'd0, 8'd0, 3'b100, 10, acc1);
        chk("ready_low_when_full", oCmdReady, 0);
        send(1'b0, 8'd255, 8'd254, 8'd0, 8'd0, 3'b111, 70000, acc5);
        chk("fifth_accept_after_clear_pop", acc5 - acc0, 65538);
        wait_idle("clear", 70000);
        chk("clear_total_writes", wcount, 65541);
        chk("clear_no_gaps", last_cyc - first_cyc, 65540);
        chk("clear_busy_low", oBusy, 0);

        // Reset in the middle of a FILL with two commands pending
        wcount = 0;
        for (i = 0; i < 100; i++) expect_wr({8'd7, 8'(3 + i)}, 3'b010);
        send(1'b1, 8'd3, 8'd7, 8'd199, 8'd0, 3'b010, 10, acc0);
        send(1'b0, 8'd9, 8'd9, 8'd0, 8'd0, 3'b111, 10, acc1);
        send(1'b0, 8'd8, 8'd8, 8'd0, 8'd0, 3'b111, 10, acc1);
        nb = 0;
        while (wcount < 100 && nb < 1000) begin
            @(negedge Clock);
            #1;
            nb++;
        end
        chk("reached_pixel_100", wcount, 100);
        Reset = 1'b1;
        #1;
        chk("reset_we_async", oWriteEnable, 0);
        @(negedge Clock);
        @(negedge Clock);
        Reset = 1'b0;
        repeat (300) @(negedge Clock);
        chk("post_reset_writes", wcount, 100);
        chk("post_reset_busy", oBusy, 0);
        chk("post_reset_ready", oCmdReady, 1);
        chk("post_reset_queue", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/vram_draw_engine.md
# vram_draw_engine

Drawing engine that writes pixels into the 256×256, 3-bit-per-pixel video memory that the VGA controller scans out. It accepts single-pixel and filled-rectangle commands over a valid/ready handshake and buffers them in a 4-entry FIFO. It issues at most one write per clock to the video memory's write port. The VGA controller uses the memory's independent read port, so the engine never stalls on scan-out.

## Interface
- CMD_DEPTH, 4: command FIFO entries (power of two).
- Clock  in  1: system clock; all state on rising edge.
- Reset  in  1: asynchronous, active-high; clears all state.
- iCmdValid  in  1: command present on iCmd* inputs.
- oCmdReady  out  1: FIFO can accept a command (= !full).
- iCmdOp  in  1: 0 = PIXEL, 1 = FILL.
- iX, iY  in  8 each: start column / row.
- iW, iH  in  8 each: FILL width-1 / height-1; ignored for PIXEL.
- iColor  in  3: {R,G,B}.
- oWriteEnable  out  1: video memory write strobe.
- oWriteAddress  out  16: {row, column} = row*256 + column.
- oWriteData  out  3: pixel colour.
- oBusy  out  1: FIFO non-empty or engine active.

## Operation
- A command is accepted on a rising edge with iCmdValid && oCmdReady. All iCmd* fields are captured into the FIFO together.
- iCmdValid while oCmdReady = 0 is ignored. The sender must hold the command until it is accepted.
- The engine FSM has two states.
  - IDLE: if the FIFO is non-empty, pop the head. Load the column counter cx=0, the row counter cy=0, and the base, size and colour registers. Go to DRAW.
  - DRAW: each cycle, emit one write at column (X+cx) mod 256, row (Y+cy) mod 256. cx increments to W, then returns to 0 while cy increments.
  - DRAW, last pixel (cx==W && cy==H): if the FIFO is non-empty, pop the next command on the same edge and stay in DRAW. Otherwise return to IDLE.
- PIXEL is treated as FILL with W=H=0, giving exactly one write.
- Scan order is row-major. A FILL writes exactly (W+1)*(H+1) pixels, and consecutive writes are on consecutive cycles.
- Coordinates wrap modulo 256 in both axes. There is no clipping. X=250, W=9 writes columns 250..255 and then 0..3.
- Clearing the whole screen is FILL with X=Y=0, W=H=255, colour 000. It takes 65536 cycles.
- Arithmetic: cx, cy, X+cx and Y+cy are all 8-bit and discard the carry.
- Simultaneous push and pop on a full FIFO is impossible because ready is 0. On a non-full FIFO, a simultaneous push and pop leaves the count unchanged.
- There is no bypass path. A command always passes through the FIFO.
- Reset asserted mid-FILL:
  - oWriteEnable drops immediately (asynchronously).
  - The FIFO is flushed and the FSM returns to IDLE.
  - The partially drawn rectangle is left as-is in memory.

## Timing
- Reset values:
  - oWriteEnable=0, oWriteAddress=0, oWriteData=0, oBusy=0, FSM=IDLE, FIFO count=0.
  - oCmdReady=1 from the first cycle after Reset deasserts.
- oWriteEnable, oWriteAddress and oWriteData are registered outputs, and all three change together.
- Latency, with the engine idle and the FIFO empty:
  - Command accepted at edge N, popped at edge N+1.
  - First write is visible from edge N+2, i.e. sampled by memory at edge N+3.
- Throughput: one pixel per clock. Back-to-back commands produce no gap between the last write of one command and the first write of the next.
- oCmdReady is combinational from the FIFO count. It falls in the cycle after the CMD_DEPTH-th unpopped push.
- oBusy is registered. It rises the cycle after the first accept. It falls the cycle after the last write, when the FIFO is empty.

## Structure
- Shared package `vram_pkg`:
  - OP_PIXEL / OP_FILL encodings.
  - VRAM_COORD_W=8, VRAM_ADDR_W=16, COLOR_W=3.
  - The command struct layout {op, x, y, w, h, color} = 36 bits.
  - The VGA controller takes its window constants (256×256) from the same package.
- One natural sub-module, `cmd_fifo`:
  - Synchronous FIFO, width 36, depth CMD_DEPTH, asynchronous active-high reset.
  - Ports: push, pop, full, empty, data.
- The FSM and counters live in the top level.

## Test plan
- Reset then single PIXEL (X=5, Y=2, colour 101) -> exactly one write, addr 0x0205, data 101, two edges after accept; oBusy high 1..3 cycles then low.
- FILL X=10, Y=20, W=2, H=1, colour 011 -> 6 consecutive writes, addrs 0x140A, 0x140B, 0x140C, 0x150A, 0x150B, 0x150C.
- Wrap: FILL X=254, Y=255, W=2, H=1 -> addrs 0xFFFE, 0xFFFF, 0xFF00, 0x00FE, 0x00FF, 0x0000.
- Backpressure: iCmdValid held high during a full-screen clear with 5 PIXEL commands queued -> oCmdReady low after 4 buffered; the 5th is accepted only after the clear pops; all 5 pixels written in order with no write gaps.
- Full clear -> 65536 writes of data 000, every address 0x0000..0xFFFF hit once, oBusy low afterwards.
- Reset asserted at pixel 100 of a queued FILL plus 2 pending commands -> oWriteEnable low without a clock edge; after release no further writes, oBusy=0, oCmdReady=1.
